// File: rtl/nn_product_accumulator.sv
// Accumulates a configured number of unsigned products, then rounds, shifts
// and saturates the sum into one unsigned result per dot-product.
module nn_product_accumulator #(
    parameter int unsigned PROD_WIDTH = 45,
    parameter int unsigned ACC_WIDTH  = 56,
    parameter int unsigned OUT_WIDTH  = 23,
    parameter int unsigned SHIFT      = 22,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  cfg_start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [PROD_WIDTH-1:0] prod_data,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StAccum, StRound, StOutput} state_e;

    // Rounding constant and saturation ceiling, both at ACC_WIDTH+1 bits.
    localparam logic [ACC_WIDTH:0] HALF    = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [ACC_WIDTH:0] OUT_MAX =
        {{(ACC_WIDTH + 1 - OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

    state_e                 state_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic                   ovf_q;
    logic [LEN_WIDTH-1:0]   count_q;

    logic [ACC_WIDTH:0]     prod_ext;
    logic [ACC_WIDTH:0]     acc_sum;
    logic [ACC_WIDTH:0]     acc_rnd;
    logic [ACC_WIDTH:0]     rnd_shift;
    logic                   rnd_sat;
    logic                   beat;

    // Datapath: extended-width add (top bit is the carry-out) and round/saturate.
    always_comb begin
        prod_ext  = {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, prod_data};
        acc_sum   = {1'b0, acc_q} + prod_ext;
        acc_rnd   = {1'b0, acc_q} + HALF;
        rnd_shift = acc_rnd >> SHIFT;
        rnd_sat   = ovf_q || (rnd_shift > OUT_MAX);
        beat      = prod_valid && prod_ready;
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            out_data   <= '0;
            out_sat    <= 1'b0;
            out_valid  <= 1'b0;
            prod_ready <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Clearing here also covers a restart in the first idle cycle.
                    acc_q <= '0;
                    ovf_q <= 1'b0;
                    if (cfg_start) begin
                        busy    <= 1'b1;
                        count_q <= cfg_len;
                        if (cfg_len != '0) begin
                            state_q    <= StAccum;
                            prod_ready <= 1'b1;
                        end else begin
                            state_q <= StRound;
                        end
                    end
                end
                StAccum: begin
                    if (beat) begin
                        acc_q   <= acc_sum[ACC_WIDTH-1:0];
                        count_q <= count_q - LEN_WIDTH'(1);
                        if (acc_sum[ACC_WIDTH]) begin
                            ovf_q <= 1'b1;
                        end
                        if (count_q == LEN_WIDTH'(1)) begin
                            state_q    <= StRound;
                            prod_ready <= 1'b0;
                        end
                    end
                end
                StRound: begin
                    out_data  <= rnd_sat ? '1 : rnd_shift[OUT_WIDTH-1:0];
                    out_sat   <= rnd_sat;
                    out_valid <= 1'b1;
                    state_q   <= StOutput;
                end
                StOutput: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_product_accumulator.sv
// Directed and randomized checks of nn_product_accumulator against an
// arithmetic reference model.
module tb_nn_product_accumulator;

    logic        ap_clk;
    logic        ap_rst;
    logic        cfg_start;
    logic [15:0] cfg_len;
    logic [44:0] prod_data;
    logic        prod_valid;
    logic        prod_ready;
    logic [22:0] out_data;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    // Narrow-accumulator instance used to provoke a carry-out.
    logic        b_start;
    logic [15:0] b_len;
    logic [45:0] b_data;
    logic        b_valid;
    logic        b_ready;
    logic [22:0] b_out_data;
    logic        b_sat;
    logic        b_out_valid;
    logic        b_out_ready;
    logic        b_busy;

    int checks = 0;
    int errors = 0;
    logic [44:0] prods[$];

    nn_product_accumulator dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .cfg_start  (cfg_start),
        .cfg_len    (cfg_len),
        .prod_data  (prod_data),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    nn_product_accumulator #(
        .PROD_WIDTH (46),
        .ACC_WIDTH  (46)
    ) dut_narrow (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .cfg_start  (b_start),
        .cfg_len    (b_len),
        .prod_data  (b_data),
        .prod_valid (b_valid),
        .prod_ready (b_ready),
        .out_data   (b_out_data),
        .out_sat    (b_sat),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .busy       (b_busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact sum, overflow when it reaches 2^accw, then round-half-up.
    task automatic model(input int accw, output logic [22:0] d, output logic s);
        logic [127:0] sum;
        logic [127:0] wrapped;
        logic [127:0] r;
        logic         ovf;
        sum = '0;
        foreach (prods[i]) sum += 128'(prods[i]);
        ovf     = (sum >> accw) != 0;
        wrapped = sum & ((128'd1 << accw) - 128'd1);
        r       = (wrapped + (128'd1 << 21)) >> 22;
        s       = ovf || (r > 128'h7fffff);
        d       = s ? 23'h7fffff : r[22:0];
    endtask

    task automatic run(input int len, input bit bubbles, input int stall, input bit poke);
        logic [22:0] ed;
        logic        es;
        model(56, ed, es);
        cfg_start = 1'b1;
        cfg_len   = len[15:0];
        tick();
        cfg_start = 1'b0;
        cfg_len   = '0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("ready_after_start", 64'(prod_ready), 64'(len != 0));
        for (int i = 0; i < len; i++) begin
            if (bubbles) begin
                prod_valid = 1'b0;
                prod_data  = 45'h1fffffffffff;
                tick();
                check("ready_in_bubble", 64'(prod_ready), 64'd1);
            end
            prod_valid = 1'b1;
            prod_data  = prods[i];
            tick();
        end
        prod_valid = 1'b0;
        check("no_valid_in_round", 64'(out_valid), 64'd0);
        check("ready_low_in_round", 64'(prod_ready), 64'd0);
        tick();
        check("out_valid", 64'(out_valid), 64'd1);
        check("out_data", 64'(out_data), 64'(ed));
        check("out_sat", 64'(out_sat), 64'(es));
        for (int i = 0; i < stall; i++) begin
            out_ready  = 1'b0;
            cfg_start  = poke;
            cfg_len    = 16'd3;
            prod_valid = 1'b1;
            prod_data  = 45'h123456789;
            tick();
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", 64'(out_data), 64'(ed));
            check("stall_sat", 64'(out_sat), 64'(es));
            check("stall_ready_low", 64'(prod_ready), 64'd0);
        end
        cfg_start  = 1'b0;
        cfg_len    = '0;
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] rnd;
        int          len;
        ap_rst      = 1'b1;
        cfg_start   = 1'b0;
        cfg_len     = '0;
        prod_data   = '0;
        prod_valid  = 1'b0;
        out_ready   = 1'b0;
        b_start     = 1'b0;
        b_len       = '0;
        b_data      = '0;
        b_valid     = 1'b0;
        b_out_ready = 1'b0;
        tick();
        tick();
        ap_rst = 1'b0;
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_sat", 64'(out_sat), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(prod_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Basic sum.
        prods = '{45'd1 << 22, 45'd1 << 22, 45'd1 << 22};
        run(3, 1'b0, 0, 1'b0);
        // Rounding boundary on both sides.
        prods = '{45'd1 << 21};
        run(1, 1'b0, 0, 1'b0);
        prods = '{(45'd1 << 21) - 45'd1};
        run(1, 1'b0, 0, 1'b0);
        // Rounded value lands exactly on 2^23.
        prods = '{45'h1fffffffffff};
        run(1, 1'b0, 0, 1'b0);
        // Bubbles, output stall and ignored cfg_start during OUTPUT.
        prods = '{45'h3a5c00123, 45'h00f0f0f0f, 45'h1234567, 45'h0abcdef01};
        run(4, 1'b1, 5, 1'b1);
        // Zero length, then an immediate restart.
        prods = {};
        run(0, 1'b0, 0, 1'b0);
        prods = '{45'd7 << 22, 45'd9 << 21};
        run(2, 1'b0, 0, 1'b0);

        // Reset after two of five products.
        cfg_start = 1'b1;
        cfg_len   = 16'd5;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1;
            prod_data  = 45'h1fffffffffff;
            tick();
        end
        prod_valid = 1'b0;
        ap_rst     = 1'b1;
        tick();
        ap_rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_ready", 64'(prod_ready), 64'd0);
        prods = '{45'd5 << 22};
        run(1, 1'b0, 0, 1'b0);

        // Randomized runs with widely varying product magnitudes.
        for (int n = 0; n < 20; n++) begin
            len = int'($urandom_range(0, 9));
            prods = {};
            for (int i = 0; i < len; i++) begin
                rnd = {$urandom, $urandom} >> $urandom_range(0, 44);
                prods.push_back(rnd[44:0]);
            end
            run(len, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
        end

        // Accumulator carry-out on a 46-bit accumulator forces saturation.
        b_start = 1'b1;
        b_len   = 16'd2;
        tick();
        b_start = 1'b0;
        b_valid = 1'b1;
        b_data  = 46'd1 << 45;
        tick();
        tick();
        b_valid = 1'b0;
        tick();
        check("carry_valid", 64'(b_out_valid), 64'd1);
        check("carry_sat", 64'(b_sat), 64'd1);
        check("carry_data", 64'(b_out_data), 64'h7fffff);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        check("carry_idle", 64'(b_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
